// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the SPI register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_regbank_pkg;

    // INIT runs the post-reset clear sweep, IDLE waits for start_i,
    // ACTIVE executes burst beats.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // Addresses from ro_base upward are read-only to the burst interface.
    function automatic logic is_protected(input logic [31:0] addr,
                                          input logic [31:0] ro_base);
        return addr >= ro_base;
    endfunction

endpackage

// File: rtl/spi_regbank_if.sv
// Transaction bus between the SPI command decoder (master) and the bank (slave).
// Latency: n/a (wires only).
// Backpressure: none on the bus itself; the master must hold off while busy_o is high.
// Ports: start_i/addr_i/wr_i open a burst, beat_i/wdata_i carry beats, stop_i closes;
//        rdata_o/rvalid_o return reads, busy_o/err_o/ptr_o report status.
interface spi_regbank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  wr_i;
    logic                  beat_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  stop_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;
    logic                  busy_o;
    logic                  err_o;
    logic [ADDR_WIDTH-1:0] ptr_o;

    modport master (
        output start_i, addr_i, wr_i, beat_i, wdata_i, stop_i,
        input  rdata_o, rvalid_o, busy_o, err_o, ptr_o
    );

    modport slave (
        input  start_i, addr_i, wr_i, beat_i, wdata_i, stop_i,
        output rdata_o, rvalid_o, busy_o, err_o, ptr_o
    );
endinterface

// File: rtl/spi_regbank_mem.sv
// Single-port synchronous RAM with registered read data (block-RAM style).
// Latency: read data appears one clock after re_i; write lands on the same edge as we_i.
// Backpressure: none; one access per cycle, caller guarantees port exclusivity.
// Ports: clk/rst_n, we_i/re_i/addr_i/wdata_i request side, rdata_o registered output.
module spi_regbank_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Output register only loads on a read, so data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_regbank.sv
// Burst-access register bank with protected top region and post-reset clear sweep.
// Latency: read beat -> rdata_o/rvalid_o one clock later; write visible to the next read beat.
// Backpressure: none per beat; busy_o high during the DEPTH-cycle sweep, inputs ignored then.
// Ports: clk, rst_n (async active-low), bus (spi_regbank_if.slave: start/addr/wr/beat/wdata/stop
//        in; rdata/rvalid/busy/err/ptr out).
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 2048,
    parameter int                    ADDR_WIDTH = $clog2(DEPTH),
    parameter int                    RO_BASE    = DEPTH - 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_regbank_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  mode_q, mode_d;      // 1 = write burst
    logic                  err_q, err_d;
    logic                  rvalid_q, rvalid_d;

    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  ptr_prot;
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] ptr_ext;
    logic [DATA_WIDTH-1:0] sweep_dat;

    // The sweep reuses the burst pointer as its address counter; DEPTH is a
    // power of two so the natural wrap returns it to 0 when the sweep ends.
    assign ptr_prot  = is_protected(32'(ptr_q), 32'(RO_BASE));
    assign ptr_inc   = ptr_q + ADDR_WIDTH'(1);
    // Zero-extend then truncate so the ID pattern works for any width ratio.
    assign ptr_ext   = {{DATA_WIDTH{1'b0}}, ptr_q};
    assign sweep_dat = ptr_prot ? ptr_ext[DATA_WIDTH-1:0] : INIT_VALUE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            ptr_q    <= '0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mode_d    = mode_q;
        err_d     = err_q;
        rvalid_d  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = bus.wdata_i;

        unique case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_wdata = sweep_dat;
                ptr_d     = ptr_inc;
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (bus.start_i) begin
                    ptr_d   = bus.addr_i;
                    mode_d  = bus.wr_i;
                    err_d   = 1'b0;
                    state_d = ACTIVE;
                end
            end

            ACTIVE: begin
                if (bus.start_i) begin
                    // Restart wins over any beat or stop in the same cycle.
                    ptr_d  = bus.addr_i;
                    mode_d = bus.wr_i;
                    err_d  = 1'b0;
                end else begin
                    // A beat alongside stop still executes before closing.
                    if (bus.beat_i) begin
                        if (mode_q) begin
                            if (ptr_prot) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we = 1'b1;
                            end
                        end else begin
                            mem_re   = 1'b1;
                            rvalid_d = 1'b1;
                        end
                        ptr_d = ptr_inc;
                    end
                    if (bus.stop_i) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = INIT;
            end
        endcase
    end

    spi_regbank_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (ptr_q),
        .wdata_i (mem_wdata),
        .rdata_o (bus.rdata_o)
    );

    assign bus.rvalid_o = rvalid_q;
    assign bus.busy_o   = (state_q == INIT);
    assign bus.err_o    = err_q;
    assign bus.ptr_o    = ptr_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: directed bursts, read data scored by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_regbank;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    spi_regbank_if #(.DATA_WIDTH(8), .ADDR_WIDTH(11)) bus ();

    spi_regbank #(
        .DATA_WIDTH (8),
        .DEPTH      (2048)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid_o pulse must match the oldest outstanding read.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rst_n === 1'b1 && bus.rvalid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: rdata 0x%0h with no read outstanding", bus.rdata_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.rdata_o !== e) begin
                    errors++;
                    $display("FAIL sb_rdata: got 0x%0h, want 0x%0h", bus.rdata_o, e);
                end
            end
        end
    end

    task automatic idle_in();
        bus.start_i = 1'b0;
        bus.addr_i  = '0;
        bus.wr_i    = 1'b0;
        bus.beat_i  = 1'b0;
        bus.wdata_i = '0;
        bus.stop_i  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic start_tx(input logic [10:0] a, input logic w);
        bus.start_i = 1'b1;
        bus.addr_i  = a;
        bus.wr_i    = w;
        step();
    endtask

    task automatic wbeat(input logic [7:0] d, input logic sp);
        bus.beat_i  = 1'b1;
        bus.wdata_i = d;
        bus.stop_i  = sp;
        step();
    endtask

    task automatic rbeat(input logic [7:0] e, input logic sp);
        exp_q.push_back(e);
        bus.beat_i = 1'b1;
        bus.stop_i = sp;
        step();
    endtask

    task automatic stop_tx();
        bus.stop_i = 1'b1;
        step();
    endtask

    task automatic read1(input logic [10:0] a, input logic [7:0] e);
        start_tx(a, 1'b0);
        rbeat(e, 1'b1);
    endtask

    // Counts cycles until busy_o drops; bounded so a stuck sweep still ends the run.
    task automatic wait_sweep(input string name);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy_o === 1'b0) done = 1'b1;
        end
        check(name, 32'(n), 32'd2048);
    endtask

    task automatic check_reset(input string p);
        check({p, "_rdata"},  32'(bus.rdata_o),  32'h0);
        check({p, "_rvalid"}, 32'(bus.rvalid_o), 32'h0);
        check({p, "_busy"},   32'(bus.busy_o),   32'h1);
        check({p, "_err"},    32'(bus.err_o),    32'h0);
        check({p, "_ptr"},    32'(bus.ptr_o),    32'h0);
    endtask

    initial begin
        idle_in();
        #3 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("rst1");
        rst_n = 1'b1;
        wait_sweep("sweep1_busy_cycles");

        // Sweep contents: cleared low region, ID pattern in the protected top.
        read1(11'h000, 8'h00);
        read1(11'h7F0, 8'hF0);
        read1(11'h7FF, 8'hFF);

        // Plain write burst then back-to-back read burst.
        start_tx(11'h010, 1'b1);
        wbeat(8'hA5, 1'b0);
        wbeat(8'h5A, 1'b0);
        wbeat(8'h3C, 1'b0);
        stop_tx();
        start_tx(11'h010, 1'b0);
        rbeat(8'hA5, 1'b0);
        rbeat(8'h5A, 1'b0);
        rbeat(8'h3C, 1'b0);
        check("burst_ptr", 32'(bus.ptr_o), 32'h013);
        stop_tx();
        check("burst_err", 32'(bus.err_o), 32'h0);

        // Write crossing into the protected region.
        start_tx(11'h7EF, 1'b1);
        wbeat(8'h11, 1'b0);
        wbeat(8'h22, 1'b1);
        step();
        check("prot_err_set", 32'(bus.err_o), 32'h1);
        start_tx(11'h7EF, 1'b0);
        check("prot_err_clr", 32'(bus.err_o), 32'h0);
        rbeat(8'h11, 1'b0);
        rbeat(8'hF0, 1'b1);

        // Read burst wrapping from the top back to 0.
        start_tx(11'h7FE, 1'b0);
        rbeat(8'hFE, 1'b0);
        rbeat(8'hFF, 1'b0);
        rbeat(8'h00, 1'b1);
        check("wrap_ptr", 32'(bus.ptr_o), 32'h001);

        // Restart with a simultaneous beat drops the beat; beat+stop writes then idles.
        start_tx(11'h020, 1'b1);
        wbeat(8'h77, 1'b0);
        bus.start_i = 1'b1;
        bus.addr_i  = 11'h030;
        bus.wr_i    = 1'b1;
        bus.beat_i  = 1'b1;
        bus.wdata_i = 8'h99;
        step();
        check("restart_ptr", 32'(bus.ptr_o), 32'h030);
        wbeat(8'h44, 1'b1);
        bus.beat_i  = 1'b1;
        bus.wdata_i = 8'hEE;
        step();
        check("idle_beat_ptr", 32'(bus.ptr_o), 32'h031);
        start_tx(11'h020, 1'b0);
        rbeat(8'h77, 1'b0);
        rbeat(8'h00, 1'b1);
        start_tx(11'h030, 1'b0);
        rbeat(8'h44, 1'b0);
        rbeat(8'h00, 1'b1);

        // Read data holds after the pulse.
        read1(11'h010, 8'hA5);
        step();
        step();
        check("rdata_hold", 32'(bus.rdata_o), 32'hA5);
        check("rvalid_low", 32'(bus.rvalid_o), 32'h0);

        // Reset during the second beat of a write burst.
        start_tx(11'h050, 1'b1);
        wbeat(8'h12, 1'b0);
        bus.beat_i  = 1'b1;
        bus.wdata_i = 8'h34;
        rst_n       = 1'b0;
        #2;
        check_reset("rst2");
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_in();
        rst_n = 1'b1;
        wait_sweep("sweep2_busy_cycles");
        read1(11'h010, 8'h00);
        read1(11'h050, 8'h00);
        read1(11'h7F5, 8'hF5);

        step();
        step();
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
